state_mem_responder: RTL and testbench
======================================

STATE_MEM_RESPONDER -- requirements
Module: state_mem_responder

Interface
REQ-001 Parameters: none; geometry fixed at 25 lanes x 64 bits (1600-bit state).
REQ-002 clock  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low clears all storage and outputs.
REQ-004 mode  input  1  1 = 25-bit slice port active, 0 = 64-bit lane port active.
REQ-005 adr25  input  6  slice index z, 0..63.
REQ-006 in25  input  [0:24]  slice write data; bit l = lane l, bit z.
REQ-007 r25  input  1  slice read strobe.
REQ-008 w25  input  1  slice write strobe.
REQ-009 out25  output  [0:24]  registered slice read data.
REQ-010 adr64  input  5  lane index l, valid 0..24.
REQ-011 in64  input  [0:63]  lane write data; bit z = lane l, bit z.
REQ-012 r64  input  1  lane read strobe.
REQ-013 w64  input  1  lane write strobe.
REQ-014 out64  output  [0:63]  registered lane read data.
REQ-015 rvalid  output  1  one-cycle pulse, read data valid on out25/out64.
REQ-016 err  output  1  one-cycle pulse, rejected access.
REQ-017 clear  input  1  pulse, starts sequential clear of storage.
REQ-018 busy  output  1  high while clear sequence runs.

Function
REQ-019 Storage SHALL be 25 lanes x 64 bits; slice z view and lane l view address the same bits (slice bit l == lane l bit z).
REQ-020 Only the port selected by mode SHALL act; strobes on the other port ignored, no err.
REQ-021 Read sampled at edge N SHALL drive out25/out64 at edge N (visible cycle N+1) with rvalid=1 for exactly that cycle; outputs hold last read value otherwise.
REQ-022 Write sampled at edge N SHALL update storage at edge N; visible to a read sampled at edge N+1.
REQ-023 Simultaneous r and w on the active port, same address: read returns pre-write data, write performed.
REQ-024 adr64 in 25..31 with r64 or w64: no storage change, out64 unchanged, rvalid=0, err=1 one cycle.
REQ-025 adr25 all values 0..63 legal; no wrap or error.
REQ-026 clear while busy=0: busy=1 next cycle; one lane zeroed per cycle, lanes 0..24 in order, lane counter 5 bits; busy=0 after lane 24 cleared (25 cycles busy).
REQ-027 clear while busy=1 SHALL be ignored.
REQ-028 Any r/w strobe while busy=1: no access, rvalid=0, err=1 one cycle.
REQ-029 clear and access in same cycle with busy=0: clear wins, access rejected with err=1.
REQ-030 mode change SHALL take effect at the next sampled edge; no in-flight state besides one read register.
REQ-031 FSM states: IDLE (serve accesses), CLEAR (count lanes 0..24, reject accesses); IDLE->CLEAR on clear, CLEAR->IDLE after lane 24.

Reset
REQ-032 reset low asynchronously: storage all zero, out25=0, out64=0, rvalid=0, err=0, busy=0, FSM=IDLE, lane counter=0.
REQ-033 reset low mid-clear SHALL abort to IDLE with all-zero state; release resumes normal operation on next edge.

Verification
REQ-034 mode=0, w64 adr64=3 in64=64'hFFFF_0000_0000_0001, then r64 adr64=3 -> next cycle out64 same value, rvalid=1 one cycle.
REQ-035 After REQ-034, mode=1, r25 adr25=0 -> out25 bit 3 = 1, others 0; adr25=63 -> out25 bit 3 = 1; adr25=20 -> out25=0.
REQ-036 mode=0, w64 adr64=27 -> err=1 one cycle, full state readback unchanged.
REQ-037 Load all lanes nonzero, pulse clear -> busy high 25 cycles, r64 during busy gives err=1, afterward every lane reads 0.
REQ-038 Same cycle r25+w25 adr25=5 in25=25'h1FFFFFF on zero state -> out25=0; next read adr25=5 -> 25'h1FFFFFF.
REQ-039 reset low at clear cycle 10 -> busy=0 immediately, all outputs 0, all reads return 0 after release.

Source files
------------

// File: rtl/state_mem_responder_if.sv
// Bus bundle for the 25x64 state memory: slice port, lane port, clear control
// and the registered response signals.
interface state_mem_responder_if;
   logic        mode;
   logic [5:0]  adr25;
   logic [0:24] in25;
   logic        r25;
   logic        w25;
   logic [0:24] out25;
   logic [4:0]  adr64;
   logic [0:63] in64;
   logic        r64;
   logic        w64;
   logic [0:63] out64;
   logic        rvalid;
   logic        err;
   logic        clear;
   logic        busy;

   modport master (
      output mode, adr25, in25, r25, w25, adr64, in64, r64, w64, clear,
      input  out25, out64, rvalid, err, busy
   );

   modport slave (
      input  mode, adr25, in25, r25, w25, adr64, in64, r64, w64, clear,
      output out25, out64, rvalid, err, busy
   );
endinterface

// File: rtl/state_mem_responder.sv
// 1600-bit state memory readable/writable as 64 slices of 25 bits or
// 25 lanes of 64 bits, with a lane-at-a-time sequential clear.
module state_mem_responder (
   input  logic                   clk,
   input  logic                   rst_n,
   state_mem_responder_if.slave   bus
);
   localparam int LANES = 25;
   localparam int W     = 64;

   typedef enum logic {IDLE, CLEAR} state_t;

   state_t                      state_q, state_d;
   logic [LANES-1:0][W-1:0]     mem_q, mem_d;
   logic [4:0]                  cnt_q, cnt_d;
   logic [0:24]                 out25_q, out25_d;
   logic [0:63]                 out64_q, out64_d;
   logic                        rvalid_q, rvalid_d;
   logic                        err_q, err_d;
   logic                        busy_q, busy_d;
   logic                        rd, wr;

   // Only the port chosen by mode counts as an access; the other is ignored.
   assign rd = bus.mode ? bus.r25 : bus.r64;
   assign wr = bus.mode ? bus.w25 : bus.w64;

   always_comb begin
      state_d  = state_q;
      mem_d    = mem_q;
      cnt_d    = cnt_q;
      out25_d  = out25_q;
      out64_d  = out64_q;
      rvalid_d = 1'b0;
      err_d    = 1'b0;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.clear) begin
               state_d = CLEAR;
               cnt_d   = 5'd0;
               busy_d  = 1'b1;
               err_d   = rd | wr;
            end else if (rd | wr) begin
               if (bus.mode) begin
                  // Slice z gathers bit z of every lane.
                  if (bus.r25) begin
                     rvalid_d = 1'b1;
                     for (int l = 0; l < LANES; l++)
                        out25_d[l] = mem_q[l][bus.adr25];
                  end
                  if (bus.w25)
                     for (int l = 0; l < LANES; l++)
                        mem_d[l][bus.adr25] = bus.in25[l];
               end else if (bus.adr64 > 5'd24) begin
                  err_d = 1'b1;
               end else begin
                  if (bus.r64) begin
                     rvalid_d = 1'b1;
                     for (int z = 0; z < W; z++)
                        out64_d[z] = mem_q[bus.adr64][z];
                  end
                  if (bus.w64)
                     for (int z = 0; z < W; z++)
                        mem_d[bus.adr64][z] = bus.in64[z];
               end
            end
         end
         CLEAR: begin
            err_d        = rd | wr;
            mem_d[cnt_q] = '0;
            if (cnt_q == 5'd24) begin
               state_d = IDLE;
               cnt_d   = 5'd0;
               busy_d  = 1'b0;
            end else begin
               cnt_d   = cnt_q + 5'd1;
               busy_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         mem_q    <= '0;
         cnt_q    <= 5'd0;
         out25_q  <= '0;
         out64_q  <= '0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mem_q    <= mem_d;
         cnt_q    <= cnt_d;
         out25_q  <= out25_d;
         out64_q  <= out64_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.out25  = out25_q;
   assign bus.out64  = out64_q;
   assign bus.rvalid = rvalid_q;
   assign bus.err    = err_q;
   assign bus.busy   = busy_q;
endmodule

// File: tb/tb_state_mem_responder.sv
// Self-checking bench: directed vector table, clear/reset sequences and a
// randomized run against a bit-matrix reference model.
module tb_state_mem_responder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   state_mem_responder_if bus();

   state_mem_responder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: plain bit matrix m[lane][z] plus remaining clear cycles.
   bit          m [25][64];
   int          m_busy;
   logic [0:24] e_out25;
   logic [0:63] e_out64;
   logic        e_rvalid, e_err, e_busy;

   localparam logic [0:63] L3 = 64'hFFFF_0000_0000_0001;
   localparam logic [0:24] S3 = 25'h020_0000;
   localparam logic [0:24] ONES25 = 25'h1FF_FFFF;
   localparam logic [0:63] Z5 = 64'h0400_0000_0000_0000;

   typedef struct {
      logic        mode;
      logic [5:0]  adr;
      logic [0:63] d64;
      logic [0:24] d25;
      logic        r, w, xport;
      logic [0:24] x25;
      logic [0:63] x64;
      logic        xv, xe;
   } vec_t;
   vec_t tbl [16];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      foreach (m[l, z]) m[l][z] = 1'b0;
      m_busy = 0;
      e_out25 = '0; e_out64 = '0; e_rvalid = 0; e_err = 0; e_busy = 0;
   endtask

   task automatic model_edge();
      bit acc;
      acc = bus.mode ? (bus.r25 | bus.w25) : (bus.r64 | bus.w64);
      e_rvalid = 0;
      e_err = 0;
      if (m_busy > 0) begin
         e_err = acc;
         for (int z = 0; z < 64; z++) m[25 - m_busy][z] = 1'b0;
         m_busy--;
      end else if (bus.clear) begin
         e_err = acc;
         m_busy = 25;
      end else if (bus.mode) begin
         if (bus.r25) begin
            e_rvalid = 1;
            for (int l = 0; l < 25; l++) e_out25[l] = m[l][bus.adr25];
         end
         if (bus.w25)
            for (int l = 0; l < 25; l++) m[l][bus.adr25] = bus.in25[l];
      end else if (bus.r64 | bus.w64) begin
         if (bus.adr64 > 24) e_err = 1;
         else begin
            if (bus.r64) begin
               e_rvalid = 1;
               for (int z = 0; z < 64; z++) e_out64[z] = m[bus.adr64][z];
            end
            if (bus.w64)
               for (int z = 0; z < 64; z++) m[bus.adr64][z] = bus.in64[z];
         end
      end
      e_busy = (m_busy > 0);
   endtask

   task automatic idle();
      bus.r25 = 0; bus.w25 = 0; bus.r64 = 0; bus.w64 = 0; bus.clear = 0;
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      chk("out25", 64'(bus.out25), 64'(e_out25));
      chk("out64", 64'(bus.out64), 64'(e_out64));
      chk("rvalid", 64'(bus.rvalid), 64'(e_rvalid));
      chk("err", 64'(bus.err), 64'(e_err));
      chk("busy", 64'(bus.busy), 64'(e_busy));
   endtask

   task automatic lane_op(logic rd, logic wr, logic [4:0] a, logic [0:63] d);
      idle();
      bus.mode = 0; bus.adr64 = a; bus.in64 = d; bus.r64 = rd; bus.w64 = wr;
      step();
   endtask

   task automatic wait_idle();
      int c;
      idle();
      c = 0;
      while (bus.busy && c < 40) begin
         step();
         c++;
      end
      chk("busy_drop", 64'(bus.busy), 64'd0);
   endtask

   function automatic vec_t mk(logic mode, logic [5:0] adr, logic [0:63] d64,
                               logic [0:24] d25, logic r, logic w, logic xp,
                               logic [0:24] x25, logic [0:63] x64, logic xv,
                               logic xe);
      vec_t v;
      v.mode = mode; v.adr = adr; v.d64 = d64; v.d25 = d25; v.r = r; v.w = w;
      v.xport = xp; v.x25 = x25; v.x64 = x64; v.xv = xv; v.xe = xe;
      return v;
   endfunction

   initial begin
      int busy_cycles;
      tbl[0]  = mk(0, 3,  L3,  '0, 0, 1, 0, '0, '0, 0, 0);
      tbl[1]  = mk(0, 3,  '0,  '0, 1, 0, 0, '0, L3, 1, 0);
      tbl[2]  = mk(0, 3,  '0,  '0, 0, 0, 0, '0, L3, 0, 0);
      tbl[3]  = mk(1, 0,  '0,  '0, 1, 0, 0, S3, L3, 1, 0);
      tbl[4]  = mk(1, 63, '0,  '0, 1, 0, 0, S3, L3, 1, 0);
      tbl[5]  = mk(1, 20, '0,  '0, 1, 0, 0, '0, L3, 1, 0);
      tbl[6]  = mk(0, 27, '1,  '0, 0, 1, 0, '0, L3, 0, 1);
      tbl[7]  = mk(0, 31, '0,  '0, 1, 0, 0, '0, L3, 0, 1);
      tbl[8]  = mk(0, 25, '1,  '0, 1, 1, 0, '0, L3, 0, 1);
      tbl[9]  = mk(1, 5,  '0,  ONES25, 1, 1, 0, S3, L3, 1, 0);
      tbl[10] = mk(1, 5,  '0,  '0, 1, 0, 0, ONES25, L3, 1, 0);
      tbl[11] = mk(1, 3,  '0,  '0, 1, 1, 1, ONES25, L3, 0, 0);
      tbl[12] = mk(0, 3,  '0,  '0, 1, 0, 0, ONES25, L3, 1, 0);
      tbl[13] = mk(0, 0,  '0,  '0, 1, 0, 0, ONES25, Z5, 1, 0);
      tbl[14] = mk(0, 24, '0,  '0, 1, 0, 0, ONES25, Z5, 1, 0);
      tbl[15] = mk(0, 24, '0,  '0, 1, 1, 1, ONES25, Z5, 0, 0);

      bus.mode = 0; bus.adr25 = '0; bus.in25 = '0; bus.adr64 = '0; bus.in64 = '0;
      idle();
      model_reset();
      #12;
      chk("rst_out25", 64'(bus.out25), 64'd0);
      chk("rst_out64", 64'(bus.out64), 64'd0);
      chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      @(negedge clk);
      rst_n = 1;

      foreach (tbl[i]) begin
         idle();
         bus.mode = tbl[i].mode;
         bus.adr25 = tbl[i].adr;
         bus.adr64 = tbl[i].adr[4:0];
         bus.in25 = tbl[i].d25;
         bus.in64 = tbl[i].d64;
         if (tbl[i].mode ^ tbl[i].xport) begin
            bus.r25 = tbl[i].r; bus.w25 = tbl[i].w;
         end else begin
            bus.r64 = tbl[i].r; bus.w64 = tbl[i].w;
         end
         step();
         chk($sformatf("vec%0d_out25", i), 64'(bus.out25), 64'(tbl[i].x25));
         chk($sformatf("vec%0d_out64", i), 64'(bus.out64), 64'(tbl[i].x64));
         chk($sformatf("vec%0d_rvalid", i), 64'(bus.rvalid), 64'(tbl[i].xv));
         chk($sformatf("vec%0d_err", i), 64'(bus.err), 64'(tbl[i].xe));
      end

      // Full lane readback after the rejected writes.
      for (int l = 0; l < 25; l++) lane_op(1, 0, 5'(l), '0);

      // Load every lane nonzero, then clear with a rejected read and an
      // ignored second clear inside the busy window.
      for (int l = 0; l < 25; l++) lane_op(0, 1, 5'(l), {$urandom, $urandom | 32'd1});
      idle();
      bus.clear = 1;
      step();
      bus.clear = 0;
      busy_cycles = 0;
      for (int c = 0; c < 40 && bus.busy; c++) begin
         busy_cycles++;
         idle();
         if (c == 3) begin bus.mode = 0; bus.adr64 = 5'd1; bus.r64 = 1; end
         if (c == 7) bus.clear = 1;
         step();
         if (c == 3) begin
            chk("busy_rd_err", 64'(bus.err), 64'd1);
            chk("busy_rd_rvalid", 64'(bus.rvalid), 64'd0);
         end
      end
      chk("busy_len", 64'(busy_cycles), 64'd25);
      for (int l = 0; l < 25; l++) begin
         lane_op(1, 0, 5'(l), '0);
         chk("cleared_lane", 64'(bus.out64), 64'd0);
      end

      // Clear and access in the same idle cycle: clear wins.
      idle();
      bus.clear = 1; bus.mode = 0; bus.adr64 = 5'd2; bus.r64 = 1;
      step();
      chk("clr_acc_err", 64'(bus.err), 64'd1);
      chk("clr_acc_busy", 64'(bus.busy), 64'd1);
      wait_idle();

      // Same-cycle slice read+write on zero state returns pre-write data.
      idle();
      bus.mode = 1; bus.adr25 = 6'd5; bus.in25 = ONES25; bus.r25 = 1; bus.w25 = 1;
      step();
      chk("rw_pre", 64'(bus.out25), 64'd0);
      bus.w25 = 0;
      step();
      chk("rw_post", 64'(bus.out25), 64'(ONES25));

      // Reset in the middle of a clear.
      for (int l = 0; l < 25; l++) lane_op(0, 1, 5'(l), {$urandom, $urandom});
      lane_op(1, 0, 5'd7, '0);
      idle();
      bus.clear = 1;
      step();
      idle();
      for (int c = 0; c < 10; c++) step();
      #2 rst_n = 0;
      model_reset();
      #1;
      chk("mid_rst_busy", 64'(bus.busy), 64'd0);
      chk("mid_rst_out25", 64'(bus.out25), 64'd0);
      chk("mid_rst_out64", 64'(bus.out64), 64'd0);
      chk("mid_rst_rvalid", 64'(bus.rvalid), 64'd0);
      chk("mid_rst_err", 64'(bus.err), 64'd0);
      @(negedge clk);
      rst_n = 1;
      for (int l = 0; l < 25; l++) lane_op(1, 0, 5'(l), '0);
      idle();
      bus.mode = 1;
      for (int z = 0; z < 64; z++) begin
         bus.adr25 = 6'(z); bus.r25 = 1;
         step();
      end

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         bus.mode  = 1'($urandom);
         bus.adr25 = 6'($urandom);
         bus.adr64 = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(25, 31))
                                                 : 5'($urandom_range(0, 24));
         bus.in25  = 25'($urandom);
         bus.in64  = {$urandom, $urandom};
         bus.r25   = 1'($urandom);
         bus.w25   = 1'($urandom);
         bus.r64   = 1'($urandom);
         bus.w64   = 1'($urandom);
         bus.clear = ($urandom_range(0, 59) == 0);
         step();
      end
      idle();
      wait_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
